vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 169 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA timing generator with built-in test patterns.
// A clock divider produces a pixel enable. Horizontal and vertical counters
// walk the sync / back porch / visible / front porch regions. Every output is
// registered on the pixel enable, using the counter values from before the
// update, so all outputs keep the same one-pixel latency.
module vga_timing_gen #(
  parameter int         CLK_DIV   = 6,
  parameter int         H_VISIBLE = 800,
  parameter int         H_FRONT   = 40,
  parameter int         H_SYNC    = 128,
  parameter int         H_BACK    = 88,
  parameter int         V_VISIBLE = 600,
  parameter int         V_FRONT   = 1,
  parameter int         V_SYNC    = 4,
  parameter int         V_BACK    = 23,
  parameter logic       H_POL     = 1'b1,
  parameter logic       V_POL     = 1'b1,
  parameter int         BAR_W     = 100,
  parameter int         CHK_BIT   = 5,
  parameter logic [3:0] SOLID_R   = 4'd7,
  parameter logic [3:0] SOLID_G   = 4'd1,
  parameter logic [3:0] SOLID_B   = 4'd14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
  localparam int H_START = H_SYNC + H_BACK;
  localparam int H_END   = H_START + H_VISIBLE;
  localparam int V_START = V_SYNC + V_BACK;
  localparam int V_END   = V_START + V_VISIBLE;

  logic [3:0]  tick;
  logic        pix_ce;
  logic [11:0] hcount;
  logic [10:0] vcount;
  logic [1:0]  mode_q;
  logic [10:0] bar_pix;
  logic [2:0]  bar_idx;
  logic        h_vis, v_vis, vis, h_last, v_last;
  logic [10:0] hx;
  logic [9:0]  vy;
  logic [3:0]  r_c, g_c, b_c;

  assign pix_ce = (tick == 4'd0);
  assign h_vis  = (hcount >= 12'(H_START)) && (hcount < 12'(H_END));
  assign v_vis  = (vcount >= 11'(V_START)) && (vcount < 11'(V_END));
  assign vis    = h_vis && v_vis;
  assign h_last = (hcount == 12'(H_TOTAL - 1));
  assign v_last = (vcount == 11'(V_TOTAL - 1));
  assign hx     = 11'(hcount - 12'(H_START));
  assign vy     = 10'(vcount - 11'(V_START));

  // Pixel enable divider; tick resets to 0 so the first edge after reset is a pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            tick <= '0;
    else if (tick == 4'(CLK_DIV - 1))   tick <= '0;
    else                                tick <= tick + 4'd1;
  end

  // Raster counters; the pattern mode is latched only at the top of a frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
      mode_q <= '0;
    end else if (pix_ce) begin
      if (hcount == '0 && vcount == '0) mode_q <= mode;
      if (h_last) begin
        hcount <= '0;
        vcount <= v_last ? '0 : vcount + 11'd1;
      end else begin
        hcount <= hcount + 12'd1;
      end
    end
  end

  // Bar index tracks the current hcount: held at 0 outside the visible span, steps every BAR_W pixels inside it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar_pix <= '0;
      bar_idx <= '0;
    end else if (pix_ce) begin
      if (!h_vis) begin
        bar_pix <= '0;
        bar_idx <= '0;
      end else if (bar_pix == 11'(BAR_W - 1)) begin
        bar_pix <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_pix <= bar_pix + 11'd1;
      end
    end
  end

  // Pattern colour for the current raster position
  always_comb begin
    r_c = '0;
    g_c = '0;
    b_c = '0;
    case (mode_q)
      2'd0: begin
        r_c = SOLID_R;
        g_c = SOLID_G;
        b_c = SOLID_B;
      end
      2'd1: begin
        r_c = {4{bar_idx[2]}};
        g_c = {4{bar_idx[1]}};
        b_c = {4{bar_idx[0]}};
      end
      2'd2: begin
        r_c = {4{hx[CHK_BIT] ^ vy[CHK_BIT]}};
        g_c = {4{hx[CHK_BIT] ^ vy[CHK_BIT]}};
        b_c = {4{hx[CHK_BIT] ^ vy[CHK_BIT]}};
      end
      default: begin
        r_c = hx[3:0];
        g_c = vy[3:0];
        b_c = hx[7:4];
      end
    endcase
  end

  // Registered outputs, updated once per pixel; line/frame pulses last one clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_ce) begin
        hsync       <= (hcount < 12'(H_SYNC)) ? H_POL : ~H_POL;
        vsync       <= (vcount < 11'(V_SYNC)) ? V_POL : ~V_POL;
        de          <= vis;
        x           <= vis ? hx : '0;
        y           <= vis ? vy : '0;
        red         <= vis ? r_c : '0;
        green       <= vis ? g_c : '0;
        blue        <= vis ? b_c : '0;
        line_start  <= (hcount == '0);
        frame_start <= (hcount == '0) && (vcount == '0);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a small raster (H 8/2/3/1, V 4/1/2/1).
// Two instances run side by side: A with CLK_DIV=2 and positive syncs, B with
// CLK_DIV=1 and negative syncs. A clock-level reference model computes the
// expected output of each instance from the number of edges since reset.
module tb_vga_timing_gen;
  localparam int HV = 8, HF = 2, HS = 3, HB = 1;
  localparam int VV = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int BW = 1, CK = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] mode = 2'd0;
  always #5 clk = ~clk;

  logic hs_a, vs_a, de_a, ls_a, fs_a, hs_b, vs_b, de_b, ls_b, fs_b;
  logic [10:0] x_a, x_b;
  logic [9:0]  y_a, y_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;

  vga_timing_gen #(.CLK_DIV(2), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .H_POL(1'b1), .V_POL(1'b1),
    .BAR_W(BW), .CHK_BIT(CK)) dut_a (
    .clk(clk), .rst(rst), .mode(mode), .hsync(hs_a), .vsync(vs_a), .de(de_a), .x(x_a), .y(y_a),
    .red(r_a), .green(g_a), .blue(b_a), .line_start(ls_a), .frame_start(fs_a));

  vga_timing_gen #(.CLK_DIV(1), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .H_POL(1'b0), .V_POL(1'b0),
    .BAR_W(BW), .CHK_BIT(CK)) dut_b (
    .clk(clk), .rst(rst), .mode(mode), .hsync(hs_b), .vsync(vs_b), .de(de_b), .x(x_b), .y(y_b),
    .red(r_b), .green(g_b), .blue(b_b), .line_start(ls_b), .frame_start(fs_b));

  typedef struct packed {
    logic hs, vs, de, ls, fs;
    logic [10:0] x;
    logic [9:0]  y;
    logic [3:0]  r, g, b;
  } out_t;

  typedef struct {
    logic [1:0]  mode;
    int          tx;
    int          ty;
    logic [11:0] rgb;
  } vec_t;

  out_t got_a, got_b;
  assign got_a = {hs_a, vs_a, de_a, ls_a, fs_a, x_a, y_a, r_a, g_a, b_a};
  assign got_b = {hs_b, vs_b, de_b, ls_b, fs_b, x_b, y_b, r_b, g_b, b_b};

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      if (errors <= 40) $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
    end
  endtask

  // Edges since reset release; -1 while in reset
  int edges = -1;
  always @(posedge clk or posedge rst)
    if (rst) edges <= -1;
    else     edges <= edges + 1;

  // Reference: output state seen after edge e for an instance with divider d
  function automatic out_t model(input int e, input int d, input logic hp, input logic vp,
                                 input logic [1:0] m);
    out_t o;
    int n, h, v, xx, yy, bar;
    o = '0;
    o.hs = ~hp;
    o.vs = ~vp;
    if (e < 0) return o;
    n = e / d;
    h = n % HT;
    v = (n / HT) % VT;
    o.hs = (h < HS) ? hp : ~hp;
    o.vs = (v < VS) ? vp : ~vp;
    o.ls = (e % d == 0) && (h == 0);
    o.fs = o.ls && (v == 0);
    if (h >= HS + HB && h < HS + HB + HV && v >= VS + VB && v < VS + VB + VV) begin
      xx = h - HS - HB;
      yy = v - VS - VB;
      o.de = 1'b1;
      o.x = 11'(xx);
      o.y = 10'(yy);
      case (m)
        2'd0: begin o.r = 4'd7; o.g = 4'd1; o.b = 4'd14; end
        2'd1: begin
          bar = xx / BW;
          o.r = ((bar & 4) != 0) ? 4'hF : 4'h0;
          o.g = ((bar & 2) != 0) ? 4'hF : 4'h0;
          o.b = ((bar & 1) != 0) ? 4'hF : 4'h0;
        end
        2'd2: begin
          o.r = ((((xx >> CK) ^ (yy >> CK)) & 1) != 0) ? 4'hF : 4'h0;
          o.g = o.r;
          o.b = o.r;
        end
        default: begin
          o.r = 4'(xx % 16);
          o.g = 4'(yy % 16);
          o.b = 4'((xx / 16) % 16);
        end
      endcase
    end
    return o;
  endfunction

  // Streaming comparison of both instances against the model on every falling edge
  initial begin
    logic [1:0] mref_a, mref_b;
    mref_a = 2'd0;
    mref_b = 2'd0;
    forever begin
      @(negedge clk);
      if (edges < 0) begin
        mref_a = 2'd0;
        mref_b = 2'd0;
      end else begin
        if (edges % 2 == 0 && (edges / 2) % (HT * VT) == 0) mref_a = mode;
        if (edges % (HT * VT) == 0) mref_b = mode;
      end
      cmp("stream_a", 64'(got_a), 64'(model(edges, 2, 1'b1, 1'b1, mref_a)));
      cmp("stream_b", 64'(got_b), 64'(model(edges, 1, 1'b0, 1'b0, mref_b)));
    end
  end

  function automatic void pstats(input logic [3:0] q[$], input int sel, input logic act,
                                 output int per, output int wid);
    int r1, r2;
    r1 = -1; r2 = -1; per = -1; wid = 0;
    for (int i = 1; i < q.size(); i++)
      if (q[i][sel] == act && q[i-1][sel] != act) begin
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
    if (r2 > 0) per = r2 - r1;
    if (r1 > 0) for (int i = r1; i < q.size() && q[i][sel] == act; i++) wid++;
  endfunction

  task automatic set_mode(input logic [1:0] m);
    @(negedge clk); #1;
    mode = m;
  endtask

  task automatic wait_fs(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (fs_a) begin ok = 1'b1; break; end
    end
  endtask

  task automatic find_px(input int tx, input int ty, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (de_a && x_a == 11'(tx) && y_a == 10'(ty)) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    vec_t tbl[16];
    logic [3:0] sa[$], sb[$];
    int per, wid, cnt, prev;
    logic ok;

    tbl[0]  = '{2'd0, 2, 1, 12'h71E};
    tbl[1]  = '{2'd1, 0, 2, 12'h000};
    tbl[2]  = '{2'd1, 1, 2, 12'h00F};
    tbl[3]  = '{2'd1, 2, 2, 12'h0F0};
    tbl[4]  = '{2'd1, 3, 2, 12'h0FF};
    tbl[5]  = '{2'd1, 4, 2, 12'hF00};
    tbl[6]  = '{2'd1, 5, 2, 12'hF0F};
    tbl[7]  = '{2'd1, 6, 2, 12'hFF0};
    tbl[8]  = '{2'd1, 7, 2, 12'hFFF};
    tbl[9]  = '{2'd2, 0, 0, 12'h000};
    tbl[10] = '{2'd2, 2, 0, 12'hFFF};
    tbl[11] = '{2'd2, 2, 2, 12'h000};
    tbl[12] = '{2'd2, 1, 3, 12'hFFF};
    tbl[13] = '{2'd3, 5, 3, 12'h530};
    tbl[14] = '{2'd3, 7, 2, 12'h720};
    tbl[15] = '{2'd0, 0, 0, 12'h71E};

    // Reset state
    repeat (3) @(negedge clk);
    cmp("reset_a", 64'(got_a), 64'(38'h0));
    cmp("reset_b", 64'({2'b11, 36'h0}), 64'(got_b));

    // Two frames of sync / enable activity straight out of reset
    for (int i = 0; i < 460; i++) begin
      @(negedge clk);
      sa.push_back({hs_a, vs_a, fs_a, de_a});
      sb.push_back({hs_b, vs_b, fs_b, de_b});
      if (i == 0) begin #1; rst = 1'b0; end
    end
    pstats(sa, 3, 1'b1, per, wid); cmp("a_hsync_period", 64'(per), 64'(28)); cmp("a_hsync_width", 64'(wid), 64'(6));
    pstats(sa, 2, 1'b1, per, wid); cmp("a_vsync_period", 64'(per), 64'(224)); cmp("a_vsync_width", 64'(wid), 64'(56));
    pstats(sa, 1, 1'b1, per, wid); cmp("a_fs_period", 64'(per), 64'(224)); cmp("a_fs_width", 64'(wid), 64'(1));
    cnt = 0;
    for (int i = 1; i < 225; i++) cnt += int'(sa[i][0]);
    cmp("a_de_clks", 64'(cnt), 64'(64));
    cmp("b_hsync_low_first", 64'(sb[1][3]), 64'(0));
    pstats(sb, 3, 1'b0, per, wid); cmp("b_hsync_period", 64'(per), 64'(14)); cmp("b_hsync_width", 64'(wid), 64'(3));
    pstats(sb, 2, 1'b0, per, wid); cmp("b_vsync_period", 64'(per), 64'(112)); cmp("b_vsync_width", 64'(wid), 64'(28));
    pstats(sb, 1, 1'b1, per, wid); cmp("b_fs_period", 64'(per), 64'(112));
    cnt = 0;
    for (int i = 1; i < 113; i++) cnt += int'(sb[i][0]);
    cmp("b_de_clks", 64'(cnt), 64'(32));

    // Pattern table: select the mode, wait for it to take effect, then probe pixels
    prev = -1;
    for (int i = 0; i < 16; i++) begin
      if (int'(tbl[i].mode) != prev) begin
        set_mode(tbl[i].mode);
        wait_fs(ok);
        cmp($sformatf("tbl%0d_fs_seen", i), 64'(ok), 64'(1));
        prev = int'(tbl[i].mode);
      end
      find_px(tbl[i].tx, tbl[i].ty, ok);
      cmp($sformatf("tbl%0d_px_seen", i), 64'(ok), 64'(1));
      cmp($sformatf("tbl%0d_rgb", i), 64'({r_a, g_a, b_a}), 64'(tbl[i].rgb));
    end

    // Mode change mid-frame only takes effect at the next frame
    set_mode(2'd0);
    wait_fs(ok);
    find_px(0, 1, ok);
    set_mode(2'd2);
    find_px(2, 3, ok);
    cmp("midframe_px_seen", 64'(ok), 64'(1));
    cmp("midframe_still_solid", 64'({r_a, g_a, b_a}), 64'(12'h71E));
    find_px(2, 0, ok);
    cmp("nextframe_px_seen", 64'(ok), 64'(1));
    cmp("nextframe_checker", 64'({r_a, g_a, b_a}), 64'(12'hFFF));

    // Reset in the middle of a frame, while hcount=5 and vcount=4 on instance A
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (edges >= 0 && edges % 2 == 1 && (edges / 2) % (HT * VT) == 4 * HT + 4) begin ok = 1'b1; break; end
    end
    cmp("midreset_point_seen", 64'(ok), 64'(1));
    #1; rst = 1'b1;
    #1;
    cmp("midreset_async_a", 64'(got_a), 64'(38'h0));
    cmp("midreset_async_b", 64'(got_b), 64'({2'b11, 36'h0}));
    repeat (3) @(negedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    cmp("restart_a_ls_fs_hs", 64'({ls_a, fs_a, hs_a, de_a}), 64'(4'b1110));
    cmp("restart_b_ls_fs_hs", 64'({ls_b, fs_b, hs_b, de_b}), 64'(4'b1100));

    // Random mode changes and occasional resets, judged by the streaming model
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(1, 150)) @(negedge clk);
      #1;
      mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        #1;
        rst = 1'b0;
      end
    end
    repeat (500) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
